// File: rtl/lsu_arb_pkg.sv
// Shared types and funct3 legality helpers for the LSU arbiter.
// funct3 encodings mirror the RISC-V load/store F_* codes.
package lsu_arb_pkg;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;
  localparam logic [2:0] F_SB  = 3'b000;
  localparam logic [2:0] F_SH  = 3'b001;
  localparam logic [2:0] F_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } lsu_arb_state_t;

  function automatic logic is_legal_load(input logic [2:0] funct3);
    case (funct3)
      F_LB, F_LH, F_LW, F_LBU, F_LHU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal_store(input logic [2:0] funct3);
    case (funct3)
      F_SB, F_SH, F_SW: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational picker: round-robin on the port that did not win
// last, or fixed priority to port 0 when 'fixed' is set.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic [1:0] gnt,
  output logic       winner
);

  // Winner selection and one-hot grant
  always_comb begin
    winner = 1'b0;
    gnt    = 2'b00;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = fixed ? 1'b0 : ~last;
      default: winner = 1'b0;
    endcase
    if (req != 2'b00) begin
      gnt = winner ? 2'b10 : 2'b01;
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares the byte-banked LSU between the core data port (m0) and the
// debug/DMA port (m1); one drive cycle per access plus a hold cycle for loads.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_funct3,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_funct3,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        lsu_write_ram,
  output logic [2:0]  lsu_funct3,
  output logic [31:0] lsu_ram_addr,
  output logic [31:0] lsu_write_data,
  input  logic [31:0] lsu_read_data
);

  lsu_arb_state_t state_r;
  logic           last_gnt_r;
  logic           we_r;
  logic           legal_r;
  logic           id_r;
  logic [1:0]     done_r;
  logic [1:0]     err_r;
  logic [31:0]    rdata0_r;
  logic [31:0]    rdata1_r;
  logic           lsu_write_ram_r;
  logic [2:0]     lsu_funct3_r;
  logic [31:0]    lsu_ram_addr_r;
  logic [31:0]    lsu_write_data_r;

  logic [1:0]     arb_gnt_s;
  logic           winner_s;
  logic [1:0]     gnt_s;
  logic           sel_we_s;
  logic [2:0]     sel_funct3_s;
  logic [31:0]    sel_addr_s;
  logic [31:0]    sel_wdata_s;
  logic           sel_legal_s;

  rr_arb2 u_rr_arb2 (
    .req    ({m1_req, m0_req}),
    .last   (last_gnt_r),
    .fixed  (FIXED_PRIO),
    .gnt    (arb_gnt_s),
    .winner (winner_s)
  );

  // Winner's request fields and IDLE-only grant gating
  always_comb begin
    sel_we_s     = 1'b0;
    sel_funct3_s = 3'b000;
    sel_addr_s   = 32'h0000_0000;
    sel_wdata_s  = 32'h0000_0000;
    gnt_s        = 2'b00;
    if (winner_s) begin
      sel_we_s     = m1_we;
      sel_funct3_s = m1_funct3;
      sel_addr_s   = m1_addr;
      sel_wdata_s  = m1_wdata;
    end else begin
      sel_we_s     = m0_we;
      sel_funct3_s = m0_funct3;
      sel_addr_s   = m0_addr;
      sel_wdata_s  = m0_wdata;
    end
    sel_legal_s = sel_we_s ? is_legal_store(sel_funct3_s) : is_legal_load(sel_funct3_s);
    if (state_r == IDLE) begin
      gnt_s = arb_gnt_s;
    end else begin
      gnt_s = 2'b00;
    end
  end

  // Access sequencer; the lsu_* registers double as the request latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      last_gnt_r       <= 1'b1;
      we_r             <= 1'b0;
      legal_r          <= 1'b0;
      id_r             <= 1'b0;
      done_r           <= 2'b00;
      err_r            <= 2'b00;
      rdata0_r         <= 32'h0000_0000;
      rdata1_r         <= 32'h0000_0000;
      lsu_write_ram_r  <= 1'b0;
      lsu_funct3_r     <= 3'b000;
      lsu_ram_addr_r   <= 32'h0000_0000;
      lsu_write_data_r <= 32'h0000_0000;
    end else begin
      done_r <= 2'b00;
      err_r  <= 2'b00;
      case (state_r)
        IDLE: begin
          if (gnt_s != 2'b00) begin
            we_r             <= sel_we_s;
            legal_r          <= sel_legal_s;
            id_r             <= winner_s;
            last_gnt_r       <= winner_s;
            lsu_write_ram_r  <= sel_we_s & sel_legal_s;
            lsu_funct3_r     <= sel_funct3_s;
            lsu_ram_addr_r   <= sel_addr_s;
            lsu_write_data_r <= sel_wdata_s;
            state_r          <= ACCESS;
          end else begin
            lsu_write_ram_r <= 1'b0;
            state_r         <= IDLE;
          end
        end
        ACCESS: begin
          lsu_write_ram_r <= 1'b0;
          if (we_r) begin
            done_r[id_r] <= 1'b1;
            err_r[id_r]  <= ~legal_r;
            state_r      <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        HOLD: begin
          // Read data resolved by the synchronous RAM; illegal loads return zero
          lsu_write_ram_r <= 1'b0;
          done_r[id_r]    <= 1'b1;
          err_r[id_r]     <= ~legal_r;
          if (id_r) begin
            rdata1_r <= legal_r ? lsu_read_data : 32'h0000_0000;
          end else begin
            rdata0_r <= legal_r ? lsu_read_data : 32'h0000_0000;
          end
          state_r <= IDLE;
        end
        default: begin
          lsu_write_ram_r <= 1'b0;
          state_r         <= IDLE;
        end
      endcase
    end
  end

  assign m0_gnt         = gnt_s[0];
  assign m1_gnt         = gnt_s[1];
  assign m0_done        = done_r[0];
  assign m1_done        = done_r[1];
  assign m0_err         = err_r[0];
  assign m1_err         = err_r[1];
  assign m0_rdata       = rdata0_r;
  assign m1_rdata       = rdata1_r;
  assign lsu_write_ram  = lsu_write_ram_r;
  assign lsu_funct3     = lsu_funct3_r;
  assign lsu_ram_addr   = lsu_ram_addr_r;
  assign lsu_write_data = lsu_write_data_r;

endmodule
